hwag_inj_channel: RTL and testbench
===================================

HWAG_INJ_CHANNEL -- requirements
Module: hwag_inj_channel

Interface
REQ-001 Parameter ANGLE_W, default 24, width of angle bus (matches ACNT2 width).
REQ-002 Parameter TIME_W, default 24, width of pulse-duration timer.
REQ-003 Parameter PRESC_W, default 4, width of timer prescaler shift.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ena  in  1  global clock enable; when 0, all state, timer and outputs hold.
REQ-007 hwag_start  in  1  angle generator synchronised; 0 forces channel inactive.
REQ-008 acnt_ena  in  1  one-cycle strobe: acnt_data has advanced one step.
REQ-009 acnt_data  in  ANGLE_W  current angle count (ACNT2 output), range 0..3839.
REQ-010 wr  in  1  one-cycle host write strobe for start_angle_in/pulse_time_in.
REQ-011 start_angle_in  in  ANGLE_W  requested injection start angle.
REQ-012 pulse_time_in  in  TIME_W  requested pulse duration in prescaled ticks; 0 = channel disabled.
REQ-013 presc  in  PRESC_W  tick = every 2^presc enabled clocks.
REQ-014 inj_out  out  1  injector drive, registered.
REQ-015 pending  out  1  host values written but not yet applied.
REQ-016 overrun  out  1  sticky: start angle reached while pulse still open.
REQ-017 state_out  out  2  current state encoding (debug).

Function
REQ-018 States: IDLE(0), ARMED(1), OPEN(2), LOCK(3); transitions only on cycles with ena=1.
REQ-019 wr=1 captures both inputs into pending registers and sets pending=1; a later wr overwrites, last write wins.
REQ-020 Pending values copy to active registers, and pending clears, on any ena cycle with state IDLE, ARMED or LOCK; never while OPEN.
REQ-021 wr and apply in same cycle: new write wins, pending stays 1, previous pending values applied.
REQ-022 IDLE -> ARMED when hwag_start=1; ARMED/OPEN/LOCK -> IDLE when hwag_start=0, with inj_out=0 on the next clock.
REQ-023 ARMED -> OPEN when acnt_ena=1, acnt_data == active start angle, and active pulse time != 0; inj_out=1 on the clock after the match cycle; timer loads active pulse time.
REQ-024 Timer decrements by 1 on each prescaler tick in OPEN; prescaler counter clears on OPEN entry.
REQ-025 Timer reaches 0 -> LOCK, inj_out=0 on the same clock edge; pulse length = pulse_time x 2^presc clocks (+/-1 clk).
REQ-026 LOCK -> ARMED on acnt_ena with acnt_data != active start angle (one pulse per revolution).
REQ-027 In OPEN, acnt_ena with match sets overrun=1; pulse not extended or restarted.
REQ-028 overrun clears only by rst.
REQ-029 Angle compare is exact equality, full ANGLE_W; wrap 3839->0 needs no special handling.
REQ-030 Timer arithmetic unsigned, no underflow past 0.

Reset
REQ-031 rst (priority over ena): state=IDLE, inj_out=0, pending=0, overrun=0, timer=0, prescaler=0, active and pending registers=0.
REQ-032 rst mid-pulse drops inj_out to 0 on the next edge.

Structure
REQ-033 Package hwag_pkg: state enum, ANGLE_W/TIME_W defaults, ACNT_TOP=3839.
REQ-034 One sub-module, hwag_pulse_timer: prescaler plus down-counter with load, tick and zero flag.

Verification
REQ-035 presc=0, angle=100, time=50, hwag_start=1, acnt steps 0..3839: inj_out rises one clk after acnt_data=100 strobe, high exactly 50 clks, one pulse per revolution.
REQ-036 presc=2, time=10: high 40 clks; wr of time=20 during OPEN keeps pending=1 until LOCK, then next revolution pulse is 80 clks.
REQ-037 time=5000 with acnt strobe every 1 clk (revolution < pulse): overrun=1 at second match; pulse ends at 5000 clks.
REQ-038 hwag_start drops mid-pulse: inj_out=0 next clk, state_out=0; re-asserting re-arms without a spurious pulse.
REQ-039 time=0: no pulse across 3 revolutions; ena=0 for 10 clks mid-pulse extends pulse by exactly 10 clks.
REQ-040 rst asserted in OPEN: all outputs 0 next clk, pending cleared.

Source files
------------

// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG injection channel.
package hwag_pkg;

  localparam int ANGLE_W_DEF = 24;
  localparam int TIME_W_DEF  = 24;
  localparam int ACNT_TOP    = 3839;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_OPEN  = 2'd2,
    ST_LOCK  = 2'd3
  } inj_state_e;

endpackage

// File: rtl/hwag_pulse_timer.sv
// Pulse duration timer: 2^presc prescaler feeding a loadable down-counter.
module hwag_pulse_timer #(
  parameter int TIME_W  = 24,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [TIME_W-1:0]  load_val,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick,
  output logic               zero,
  output logic [TIME_W-1:0]  count
);

  localparam int PCNT_W = 2 ** PRESC_W;

  logic [PCNT_W-1:0] presc_cnt;
  logic [PCNT_W-1:0] presc_mask;

  // Tick fires when the prescaler has seen 2^presc running clocks.
  assign presc_mask = ~({PCNT_W{1'b1}} << presc);
  assign tick       = run && (presc_cnt == presc_mask);
  assign zero       = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      presc_cnt <= '0;
    end else if (load) begin
      count     <= load_val;
      presc_cnt <= '0;
    end else if (run) begin
      presc_cnt <= tick ? '0 : presc_cnt + PCNT_W'(1);
      if (tick && !zero)
        count <= count - TIME_W'(1);
    end
  end

endmodule

// File: rtl/hwag_inj_channel.sv
// One injector channel: opens at a programmed angle, closes after a timed pulse,
// and fires at most once per revolution.
module hwag_inj_channel
  import hwag_pkg::*;
#(
  parameter int ANGLE_W = ANGLE_W_DEF,
  parameter int TIME_W  = TIME_W_DEF,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               hwag_start,
  input  logic               acnt_ena,
  input  logic [ANGLE_W-1:0] acnt_data,
  input  logic               wr,
  input  logic [ANGLE_W-1:0] start_angle_in,
  input  logic [TIME_W-1:0]  pulse_time_in,
  input  logic [PRESC_W-1:0] presc,
  output logic               inj_out,
  output logic               pending,
  output logic               overrun,
  output logic [1:0]         state_out
);

  inj_state_e state, state_next;

  logic [ANGLE_W-1:0] pend_angle, act_angle;
  logic [TIME_W-1:0]  pend_time, act_time;
  logic [TIME_W-1:0]  timer_count;
  logic               angle_match, apply, pulse_done;
  logic               timer_load, timer_run, timer_tick, timer_zero;

  assign angle_match = acnt_ena && (acnt_data == act_angle);
  assign apply       = ena && pending && (state != ST_OPEN);
  assign timer_run   = ena && (state == ST_OPEN);
  assign timer_load  = ena && (state == ST_ARMED) && (state_next == ST_OPEN);
  assign pulse_done  = timer_tick && (timer_zero || (timer_count == TIME_W'(1)));
  assign state_out   = state;

  hwag_pulse_timer #(
    .TIME_W  (TIME_W),
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .run      (timer_run),
    .load_val (act_time),
    .presc    (presc),
    .tick     (timer_tick),
    .zero     (timer_zero),
    .count    (timer_count)
  );

  // Losing hwag_start always wins; LOCK waits for the angle to move off the match.
  always_comb begin
    state_next = state;
    if (!hwag_start) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_ARMED;
        ST_ARMED: if (angle_match && (act_time != '0)) state_next = ST_OPEN;
        ST_OPEN:  if (pulse_done) state_next = ST_LOCK;
        ST_LOCK:  if (acnt_ena && !angle_match) state_next = ST_ARMED;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      inj_out <= 1'b0;
    end else if (ena) begin
      state   <= state_next;
      inj_out <= (state_next == ST_OPEN);
    end
  end

  // A write in the same cycle as an apply lands in the pending slot and keeps it flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_angle <= '0;
      pend_time  <= '0;
      act_angle  <= '0;
      act_time   <= '0;
      pending    <= 1'b0;
    end else begin
      if (apply) begin
        act_angle <= pend_angle;
        act_time  <= pend_time;
        pending   <= 1'b0;
      end
      if (ena && wr) begin
        pend_angle <= start_angle_in;
        pend_time  <= pulse_time_in;
        pending    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (ena && (state == ST_OPEN) && angle_match)
      overrun <= 1'b1;
  end

endmodule

// File: tb/tb_hwag_inj_channel.sv
// Directed bench for hwag_inj_channel: pulse timing, pending apply, overrun, resets.
module tb_hwag_inj_channel;
  import hwag_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        hwag_start = 1'b0;
  logic        acnt_ena = 1'b0;
  logic [23:0] acnt_data = '0;
  logic        wr = 1'b0;
  logic [23:0] start_angle_in = '0;
  logic [23:0] pulse_time_in = '0;
  logic [3:0]  presc = '0;
  logic        inj_out, pending, overrun;
  logic [1:0]  state_out;

  int checks = 0;
  int failures = 0;
  int pos = 0;
  int angle_cfg = 100;
  int cyc = 0;
  int match_cyc = 0;
  int pulses = 0, ended = 0, cur_len = 0, first_len = 0, last_len = 0, rise_lat = -1;
  logic prev_inj = 1'b0;

  hwag_inj_channel dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .hwag_start     (hwag_start),
    .acnt_ena       (acnt_ena),
    .acnt_data      (acnt_data),
    .wr             (wr),
    .start_angle_in (start_angle_in),
    .pulse_time_in  (pulse_time_in),
    .presc          (presc),
    .inj_out        (inj_out),
    .pending        (pending),
    .overrun        (overrun),
    .state_out      (state_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge and pulse statistics updated.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    if (inj_out && !prev_inj) begin
      pulses++;
      cur_len = 0;
      if (pulses == 1) rise_lat = cyc - match_cyc;
    end
    if (inj_out) cur_len++;
    if (!inj_out && prev_inj) begin
      ended++;
      last_len = cur_len;
      if (ended == 1) first_len = cur_len;
    end
    prev_inj = inj_out;
  endtask

  task automatic clearStats();
    pulses = 0; ended = 0; first_len = 0; last_len = 0; rise_lat = -1;
  endtask

  task automatic runAngle(input int steps);
    for (int i = 0; i < steps; i++) begin
      acnt_data = pos[23:0];
      acnt_ena  = 1'b1;
      if (pos == angle_cfg) match_cyc = cyc + 1;
      applyStimulus();
      acnt_ena = 1'b0;
      pos = (pos == ACNT_TOP) ? 0 : pos + 1;
    end
  endtask

  task automatic hostWrite(input int angle, input int ptime);
    start_angle_in = angle[23:0];
    pulse_time_in  = ptime[23:0];
    wr = 1'b1;
    applyStimulus();
    wr = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1; ena = 1'b1; hwag_start = 1'b0; acnt_ena = 1'b0; wr = 1'b0;
    applyStimulus();
    rst = 1'b0;
    pos = 0;
  endtask

  initial begin
    // Reset state and basic 50-clock pulse, two revolutions
    resetDut();
    checkOutput("rst_state", state_out, 0);
    checkOutput("rst_inj", inj_out, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_overrun", overrun, 0);
    presc = 4'd0;
    hostWrite(100, 50);
    checkOutput("wr_pending_set", pending, 1);
    applyStimulus();
    checkOutput("idle_apply_clears", pending, 0);
    hwag_start = 1'b1;
    clearStats();
    runAngle(7680);
    checkOutput("t1_pulses", pulses, 2);
    checkOutput("t1_rise_lat", rise_lat, 0);
    checkOutput("t1_first_len", first_len, 50);
    checkOutput("t1_last_len", last_len, 50);
    checkOutput("t1_overrun", overrun, 0);

    // Prescaled pulse, rewrite during OPEN held until LOCK
    resetDut();
    presc = 4'd2;
    hostWrite(100, 10);
    applyStimulus();
    hwag_start = 1'b1;
    clearStats();
    runAngle(101);
    checkOutput("t2_open", state_out, 2);
    hostWrite(100, 20);
    checkOutput("t2_pend_open", pending, 1);
    runAngle(20);
    checkOutput("t2_pend_hold", pending, 1);
    checkOutput("t2_still_open", state_out, 2);
    runAngle(7559);
    checkOutput("t2_pend_applied", pending, 0);
    checkOutput("t2_pulses", pulses, 2);
    checkOutput("t2_first_len", first_len, 40);
    checkOutput("t2_last_len", last_len, 80);

    // Pulse longer than a revolution raises overrun
    resetDut();
    presc = 4'd0;
    hostWrite(100, 5000);
    applyStimulus();
    hwag_start = 1'b1;
    clearStats();
    runAngle(101);
    checkOutput("t3_overrun_pre", overrun, 0);
    runAngle(3840);
    checkOutput("t3_overrun_set", overrun, 1);
    checkOutput("t3_inj_held", inj_out, 1);
    runAngle(2000);
    checkOutput("t3_pulses", pulses, 1);
    checkOutput("t3_len", first_len, 5000);
    checkOutput("t3_overrun_sticky", overrun, 1);

    // Last write wins; hwag_start drop mid-pulse and clean re-arm
    resetDut();
    presc = 4'd2;
    hostWrite(300, 50);
    hostWrite(100, 50);
    checkOutput("t4_pend_wr_apply", pending, 1);
    applyStimulus();
    checkOutput("t4_pend_clear", pending, 0);
    hwag_start = 1'b1;
    clearStats();
    runAngle(101);
    checkOutput("t4_open_at_100", state_out, 2);
    checkOutput("t4_rise_lat", rise_lat, 0);
    runAngle(10);
    hwag_start = 1'b0;
    applyStimulus();
    checkOutput("t4_drop_inj", inj_out, 0);
    checkOutput("t4_drop_state", state_out, 0);
    applyStimulus();
    hwag_start = 1'b1;
    applyStimulus();
    checkOutput("t4_rearm_state", state_out, 1);
    clearStats();
    runAngle(3000);
    checkOutput("t4_no_spurious", pulses, 0);
    runAngle(1080);
    checkOutput("t4_pulses", pulses, 1);
    checkOutput("t4_len", last_len, 200);

    // Zero pulse time disables; ena low stretches a pulse
    resetDut();
    presc = 4'd0;
    hostWrite(100, 0);
    applyStimulus();
    hwag_start = 1'b1;
    clearStats();
    runAngle(3 * 3840);
    checkOutput("t5_zero_no_pulse", pulses, 0);
    checkOutput("t5_zero_armed", state_out, 1);
    hostWrite(100, 50);
    clearStats();
    runAngle(121);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("t5_ena_hold_inj", inj_out, 1);
    checkOutput("t5_ena_hold_state", state_out, 2);
    ena = 1'b1;
    runAngle(100);
    checkOutput("t5_pulses", pulses, 1);
    checkOutput("t5_stretched_len", last_len, 60);

    // Reset while OPEN
    resetDut();
    hostWrite(100, 50);
    applyStimulus();
    hwag_start = 1'b1;
    runAngle(111);
    checkOutput("t6_open", inj_out, 1);
    hostWrite(200, 30);
    checkOutput("t6_pend", pending, 1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("t6_rst_inj", inj_out, 0);
    checkOutput("t6_rst_pending", pending, 0);
    checkOutput("t6_rst_state", state_out, 0);
    checkOutput("t6_rst_overrun", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
